// File: rtl/dino_pkg.sv
// ============================================================================
// Module   : dino_pkg
// Purpose  : Shared grid layout, game states and LFSR taps for the dino game.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int GRID_W          = 8;
    localparam int COL0_GROUND_BIT = 7;
    localparam int COL0_AIR_BIT    = 15;

    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of the shift register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_feedback(input logic [7:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dino_lfsr.sv
// ============================================================================
// Module   : dino_lfsr
// Purpose  : 8-bit Fibonacci LFSR, left shifting, advances only when enabled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dino_lfsr
    import dino_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/dino_world.sv
// ============================================================================
// Module   : dino_world
// Purpose  : Ground obstacles, collision, game FSM, score and LED row scanning.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dino_world
    import dino_pkg::*;
#(
    parameter int         SCAN_DIV  = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         MIN_GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dino_grid,
    input  logic        start_button,
    input  logic        step_tick,
    output logic [15:0] frame,
    output logic        scan_row,
    output logic [7:0]  scan_cols,
    output logic        game_over,
    output logic [7:0]  score
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_e             state_q, state_d;
    logic [GRID_W-1:0]  obs_q, obs_d;
    logic [7:0]         score_q, score_d;
    logic [15:0]        frame_q, frame_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic               scan_row_q, scan_row_d;
    logic [7:0]         scan_cols_q, scan_cols_d;

    logic               collision;
    logic               advance;
    logic               spawn;
    logic [7:0]         lfsr_value;

    dino_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .value (lfsr_value)
    );

    // Collision wins over a same-cycle step, so the world freezes unshifted
    always_comb begin
        collision = (state_q == RUN) && (|(dino_grid[GRID_W-1:0] & obs_q));
        advance   = (state_q == RUN) && !collision && step_tick;
        spawn     = (lfsr_value[1:0] == 2'b00) && (obs_q[MIN_GAP-1:0] == '0);

        state_d = state_q;
        obs_d   = obs_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                obs_d   = '0;
                score_d = '0;
                if (start_button) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (collision) begin
                    state_d = OVER;
                end else if (step_tick) begin
                    obs_d = {obs_q[GRID_W-2:0], spawn};
                    if (obs_q[COL0_GROUND_BIT] && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                end
            end
            OVER: begin
                if (start_button) begin
                    state_d = RUN;
                    obs_d   = '0;
                    score_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scanner free-runs in every state; scan_cols follows the upcoming row
    always_comb begin
        frame_d    = {dino_grid[15:8], dino_grid[7:0] | obs_q};
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        scan_row_d = scan_row_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            scan_row_d = !scan_row_q;
        end
        scan_cols_d = scan_row_d ? frame_q[15:8] : frame_q[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            obs_q       <= '0;
            score_q     <= '0;
            frame_q     <= '0;
            scan_cnt_q  <= '0;
            scan_row_q  <= 1'b0;
            scan_cols_q <= '0;
        end else begin
            state_q     <= state_d;
            obs_q       <= obs_d;
            score_q     <= score_d;
            frame_q     <= frame_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_row_q  <= scan_row_d;
            scan_cols_q <= scan_cols_d;
        end
    end

    assign frame     = frame_q;
    assign scan_row  = scan_row_q;
    assign scan_cols = scan_cols_q;
    assign game_over = (state_q == OVER);
    assign score     = score_q;

endmodule

`default_nettype wire

// File: tb/tb_dino_world.sv
// ============================================================================
// Module   : tb_dino_world
// Purpose  : Self-checking bench for dino_world against a column-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dino_world;

    localparam int         SCAN_DIV  = 4;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam int         MIN_GAP   = 2;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [15:0] dino_grid    = 16'h0000;
    logic        start_button = 1'b0;
    logic        step_tick    = 1'b0;
    logic [15:0] frame;
    logic        scan_row;
    logic [7:0]  scan_cols;
    logic        game_over;
    logic [7:0]  score;

    int errors = 0;
    int checks = 0;

    dino_world #(
        .SCAN_DIV  (SCAN_DIV),
        .LFSR_SEED (LFSR_SEED),
        .MIN_GAP   (MIN_GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dino_grid    (dino_grid),
        .start_button (start_button),
        .step_tick    (step_tick),
        .frame        (frame),
        .scan_row     (scan_row),
        .scan_cols    (scan_cols),
        .game_over    (game_over),
        .score        (score)
    );

    initial forever #5 clk = ~clk;

    // Model: m_col[c] is an obstacle in column c (0 = leftmost, where the dino stands)
    int          m_mode   = 0;
    bit          m_col[8];
    int          m_lfsr   = int'(LFSR_SEED);
    int          m_score  = 0;
    int          m_clears = 0;
    logic [15:0] m_frame  = 16'h0000;
    bit          m_row    = 1'b0;
    logic [7:0]  m_scan   = 8'h00;
    int          m_cnt    = 0;
    bit          cmp_en   = 1'b0;
    bit          gap_en   = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_obs();
        logic [7:0] v = 8'h00;
        for (int c = 0; c < 8; c++) v[7-c] = m_col[c];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        for (int c = 0; c < 8; c++) m_col[c] = 1'b0;
        m_lfsr = int'(LFSR_SEED);
        m_score = 0;
        m_frame = 16'h0000;
        m_row = 1'b0;
        m_scan = 8'h00;
        m_cnt = 0;
    endtask

    task automatic model_step();
        logic [15:0] old_frame = m_frame;
        bit hit = 1'b0;
        bit sp;
        m_frame = {dino_grid[15:8], dino_grid[7:0] | m_obs()};
        if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0;
            m_row = !m_row;
        end else begin
            m_cnt++;
        end
        m_scan = m_row ? old_frame[15:8] : old_frame[7:0];
        case (m_mode)
            0: if (start_button) m_mode = 1;
            1: begin
                for (int c = 0; c < 8; c++) if (m_col[c] && dino_grid[7-c]) hit = 1'b1;
                if (hit) begin
                    m_mode = 2;
                end else if (step_tick) begin
                    if (m_col[0]) begin
                        m_clears++;
                        if (m_score < 255) m_score++;
                    end
                    sp = (m_lfsr % 4 == 0);
                    for (int c = 8 - MIN_GAP; c < 8; c++) if (m_col[c]) sp = 1'b0;
                    for (int c = 0; c < 7; c++) m_col[c] = m_col[c+1];
                    m_col[7] = sp;
                    m_lfsr = ((m_lfsr << 1) |
                              (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
                end
            end
            default: if (start_button) begin
                m_mode = 1;
                for (int c = 0; c < 8; c++) m_col[c] = 1'b0;
                m_score = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step();
    end

    // Per-cycle comparison, plus obstacle spacing seen in the DUT frame
    initial forever begin
        @(negedge clk);
        if (cmp_en && !reset) begin
            chk("frame", frame, m_frame);
            chk("score", {8'h00, score}, 16'(m_score));
            chk("game_over", {15'h0, game_over}, {15'h0, m_mode == 2});
            chk("scan_row", {15'h0, scan_row}, {15'h0, m_row});
            chk("scan_cols", {8'h00, scan_cols}, {8'h00, m_scan});
            if (gap_en) begin
                logic [7:0] of = frame[15] ? frame[7:0] : {1'b0, frame[6:0]};
                int last = -1;
                bit ok = 1'b1;
                for (int c = 0; c < 8; c++) begin
                    if (of[7-c]) begin
                        if (last >= 0 && (c - last - 1) < MIN_GAP) ok = 1'b0;
                        last = c;
                    end
                end
                chk("gap", {15'h0, ok}, 16'h0001);
            end
        end
    end

    task automatic cyc(input logic st, input logic stp, input logic [15:0] g);
        @(negedge clk);
        start_button = st;
        step_tick    = stp;
        dino_grid    = g;
    endtask

    // Jump exactly when an obstacle sits in column 0, otherwise stay grounded
    task automatic jcyc(input logic stp);
        @(negedge clk);
        start_button = 1'b0;
        step_tick    = stp;
        dino_grid    = m_col[0] ? 16'h8000 : 16'h0080;
    endtask

    initial begin
        logic [15:0] idle_grids [4] = '{16'h0080, 16'h8000, 16'h0000, 16'h0081};
        bit done;
        int n;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_frame", frame, 16'h0000);
        chk("rst_game_over", {15'h0, game_over}, 16'h0000);
        chk("rst_score", {8'h00, score}, 16'h0000);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, idle_grids[i % 4]);
        chk("idle_score", {8'h00, score}, 16'h0000);
        chk("idle_game_over", {15'h0, game_over}, 16'h0000);

        // First spawn comes from the fifth LFSR value (8'h54)
        cyc(1'b1, 1'b0, 16'h0080);
        cyc(1'b0, 1'b0, 16'h0080);
        repeat (5) begin
            cyc(1'b0, 1'b1, 16'h0080);
            cyc(1'b0, 1'b0, 16'h0080);
        end
        cyc(1'b0, 1'b0, 16'h0080);
        chk("model_lfsr_5", 16'(m_lfsr), 16'h00A9);
        chk("first_spawn_frame", frame, 16'h0081);

        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1'b0, 1'b1, 16'h0080);
            if (game_over) done = 1'b1;
            cyc(1'b0, 1'b0, 16'h0080);
            if (game_over) done = 1'b1;
        end
        chk("collide_reached", {15'h0, done}, 16'h0001);
        chk("collide_frame", frame, 16'h0080);
        chk("collide_score", {8'h00, score}, 16'h0000);
        repeat (3) begin
            cyc(1'b0, 1'b1, 16'h0080);
            cyc(1'b0, 1'b0, 16'h0080);
        end
        chk("frozen_frame", frame, 16'h0080);
        chk("frozen_game_over", {15'h0, game_over}, 16'h0001);

        // Long jumping run: spacing and saturation
        cyc(1'b1, 1'b0, 16'h8000);
        gap_en = 1'b1;
        n = 0;
        while ((m_clears < 260 || n < 500) && n < 8000) begin
            jcyc(1'b1);
            jcyc(1'b0);
            n++;
        end
        gap_en = 1'b0;
        chk("clears_reached", {15'h0, m_clears >= 260}, 16'h0001);
        chk("score_saturated", {8'h00, score}, 16'h00FF);
        chk("run_no_over", {15'h0, game_over}, 16'h0000);

        // Collision in the same cycle as a step
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            start_button = 1'b0;
            dino_grid    = 16'h0080;
            if (m_col[0]) begin
                step_tick = 1'b1;
                done = 1'b1;
            end else begin
                step_tick = (i % 2 == 0);
            end
        end
        chk("step_collide_found", {15'h0, done}, 16'h0001);
        cyc(1'b0, 1'b0, 16'h8000);
        chk("step_collide_over", {15'h0, game_over}, 16'h0001);
        chk("step_collide_score", {8'h00, score}, 16'h00FF);
        cyc(1'b0, 1'b1, 16'h8000);
        cyc(1'b0, 1'b0, 16'h8000);
        chk("step_collide_obs_held", frame & 16'h8080, 16'h8080);

        cyc(1'b1, 1'b0, 16'h8000);
        cyc(1'b0, 1'b0, 16'h8000);
        chk("restart_game_over", {15'h0, game_over}, 16'h0000);
        chk("restart_score", {8'h00, score}, 16'h0000);
        cyc(1'b0, 1'b0, 16'h8000);
        chk("restart_frame", frame, 16'h8000);

        // Asynchronous reset in the middle of a run
        n = 0;
        while (m_score < 1 && n < 200) begin
            jcyc(1'b1);
            jcyc(1'b0);
            n++;
        end
        chk("pre_reset_score", {15'h0, m_score >= 1}, 16'h0001);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_frame", frame, 16'h0000);
        chk("mid_rst_score", {8'h00, score}, 16'h0000);
        chk("mid_rst_game_over", {15'h0, game_over}, 16'h0000);
        chk("mid_rst_scan_row", {15'h0, scan_row}, 16'h0000);
        chk("mid_rst_scan_cols", {8'h00, scan_cols}, 16'h0000);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, idle_grids[i % 4]);
        chk("post_rst_score", {8'h00, score}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
